bp_be_fe_queue_fifo: RTL and testbench
======================================

Name: bp_be_fe_queue_fifo

Overview:
- Back-end-side buffer that directly consumes the FE fetch/exception message stream (fe_queue_o/v_o, gated by fe_queue_ready_i).
- Holds up to els_p messages, hands them to BE issue in order, and keeps a committed checkpoint.
- Supports speculative dequeue, commit, roll-back to the checkpoint, and full flush on FE redirect.

Parameters:
fe_queue_width_p, 128, width in bits of one bp_fe_queue_s message (opaque to this block)
els_p, 8, entry count; power of 2, >= 2
ptr_width_lp, clog2(els_p)+1, pointer width including wrap bit (localparam)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fe_queue_i  in  fe_queue_width_p  message from FE
fe_queue_v_i  in  1  message valid; FE raises only when fe_queue_ready_o=1
fe_queue_ready_o  out  1  space available for enqueue
fe_queue_o  out  fe_queue_width_p  message at speculative read pointer
fe_queue_v_o  out  1  fe_queue_o valid
fe_queue_yumi_i  in  1  BE consumes fe_queue_o this cycle (speculative dequeue)
commit_v_i  in  1  oldest speculatively dequeued entry retires; checkpoint advances by 1
roll_v_i  in  1  replay: read pointer returns to checkpoint
clr_v_i  in  1  flush all entries (FE redirect issued)
count_o  out  ptr_width_lp  entries held, including not-yet-committed ones (wptr-cptr)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i. All state (pointers, storage) clears on reset_n_i=0, independent of clk_i.
- Reset values: fe_queue_ready_o=1, fe_queue_v_o=0, fe_queue_o=0, count_o=0.
- Storage: flop array of els_p entries, written at wptr on enqueue. Read is combinational at rptr, so fe_queue_o is visible the cycle after enqueue. Zero-latency bypass is not allowed.
- Pointers: wptr (write), rptr (speculative read), cptr (checkpoint), each ptr_width_lp wide. Index = low bits; the MSB is the wrap bit, and all arithmetic is mod 2^ptr_width_lp.
- Status:
  - full = (wptr - cptr) == els_p; fe_queue_ready_o = ~full.
  - fe_queue_v_o = (rptr != wptr).
  - count_o = wptr - cptr.
  - Entries between cptr and rptr are protected; enqueue never overwrites them.
- Enqueue: accepted when fe_queue_v_i & fe_queue_ready_o; wptr += 1. fe_queue_v_i while full is ignored, and a debug assertion fires.
- Speculative dequeue: fe_queue_yumi_i & fe_queue_v_o → rptr += 1. Yumi while fe_queue_v_o=0 is ignored, and a debug assertion fires.
- Commit: commit_v_i & (cptr != rptr) → cptr += 1. Commit with cptr==rptr is ignored, and a debug assertion fires.
- Per-cycle priority: clr > roll > normal.
  - clr_v_i: rptr ← wptr_next and cptr ← wptr_next, where wptr_next = wptr (any same-cycle enqueue is dropped and wptr is unchanged). Same-cycle yumi, commit and roll are ignored. Result: empty, ready=1, v=0 next cycle.
  - roll_v_i (no clr): commit applies first, then rptr ← updated cptr. Same-cycle yumi is ignored. Same-cycle enqueue is accepted normally.
  - Normal: enqueue, yumi and commit are evaluated in parallel. Simultaneous enqueue+yumi when one entry is available: both happen.
- Full boundary: commit in the same cycle as full frees a slot next cycle only (ready is not combinationally dependent on commit_v_i).
- Wrap-around: pointers wrap through 2^ptr_width_lp with no special-case behaviour; full and empty are distinguished by the wrap bit.
- Reset mid-operation: asynchronous reset_n_i=0 discards all entries immediately. Outputs take their reset values before the next clock edge.
- No combinational path from any input to fe_queue_ready_o or fe_queue_v_o (both are decoded from registered pointers only).

Test Plan:
1. els_p=4: reset, enqueue A,B,C,D back-to-back → ready=0 after D, count_o=4; fe_queue_o=A with v=1 from the cycle after A's enqueue.
2. Yumi ×2 (A,B consumed), roll_v_i=1 → next cycle fe_queue_o=A, count_o=4; yumi A, commit ×1 → count_o=3, ready=1.
3. Full queue, yumi all four, commit ×4 in consecutive cycles → v=0, count_o=0, ready=1; then 6 further enqueue/yumi/commit rounds → wrap bit toggles, data order preserved.
4. Two entries queued, clr_v_i with simultaneous fe_queue_v_i, yumi, commit and roll → next cycle v=0, count_o=0, the new entry is not stored.
5. roll_v_i and commit_v_i together with cptr=0, rptr=2 → cptr=1, rptr=1, fe_queue_o=entry 1.
6. Assert reset_n_i low between clock edges with 3 entries held → v=0, ready=1, count_o=0, fe_queue_o=0 immediately; illegal yumi/commit on empty produce no pointer change.

Source files
------------

// File: rtl/bp_be_fe_queue_fifo_if.sv
// Handshake bundle between the FE message stream, BE issue/commit control and the FE queue.
// The slave modport is the queue; the master modport is whoever drives FE data and BE control.
interface bp_be_fe_queue_fifo_if #(
   parameter int unsigned fe_queue_width_p = 128,
   parameter int unsigned els_p            = 8
);
   localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;

   logic [fe_queue_width_p-1:0] fe_queue_i;
   logic                        fe_queue_v_i;
   logic                        fe_queue_ready_o;
   logic [fe_queue_width_p-1:0] fe_queue_o;
   logic                        fe_queue_v_o;
   logic                        fe_queue_yumi_i;
   logic                        commit_v_i;
   logic                        roll_v_i;
   logic                        clr_v_i;
   logic [ptr_width_lp-1:0]     count_o;

   modport slave (
      input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
      output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
   );

   modport master (
      output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
      input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
   );
endinterface

// File: rtl/bp_be_fe_queue_fifo.sv
// FE-to-BE message queue with speculative read pointer, committed checkpoint,
// roll-back to the checkpoint and full flush.
module bp_be_fe_queue_fifo #(
   parameter int unsigned fe_queue_width_p = 128,
   parameter int unsigned els_p            = 8,
   parameter bit          debug_p          = 1'b1
) (
   input logic                   clk_i,
   input logic                   reset_n_i,
   bp_be_fe_queue_fifo_if.slave  fe_if
);
   localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;
   localparam int unsigned idx_width_lp = ptr_width_lp - 1;

   logic [ptr_width_lp-1:0]     wptr_q, wptr_d;
   logic [ptr_width_lp-1:0]     rptr_q, rptr_d;
   logic [ptr_width_lp-1:0]     cptr_q, cptr_d;
   logic [ptr_width_lp-1:0]     cptr_commit;
   logic [ptr_width_lp-1:0]     count;
   logic [fe_queue_width_p-1:0] mem_q [els_p];
   logic                        full, not_empty;
   logic                        enq, deq, cmt, we;

   // Status is decoded from registered pointers only; no input reaches ready/valid.
   assign count     = wptr_q - cptr_q;
   assign full      = (count == ptr_width_lp'(els_p));
   assign not_empty = (rptr_q != wptr_q);

   assign fe_if.fe_queue_ready_o = ~full;
   assign fe_if.fe_queue_v_o     = not_empty;
   assign fe_if.count_o          = count;
   assign fe_if.fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];

   assign enq = fe_if.fe_queue_v_i & ~full;
   assign deq = fe_if.fe_queue_yumi_i & not_empty;
   assign cmt = fe_if.commit_v_i & (cptr_q != rptr_q);

   assign cptr_commit = cmt ? cptr_q + 1'b1 : cptr_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cptr_d = cptr_q;
      we     = 1'b0;
      if (fe_if.clr_v_i) begin
         // Flush drops any same-cycle enqueue, so wptr holds.
         rptr_d = wptr_q;
         cptr_d = wptr_q;
      end else begin
         if (enq) begin
            wptr_d = wptr_q + 1'b1;
            we     = 1'b1;
         end
         cptr_d = cptr_commit;
         if (fe_if.roll_v_i) begin
            rptr_d = cptr_commit;
         end else if (deq) begin
            rptr_d = rptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[wptr_q[idx_width_lp-1:0]] <= fe_if.fe_queue_i;
      end
   end

   // Illegal handshakes are dropped by the datapath; these flag them during debug.
   always_ff @(posedge clk_i) begin
      if (debug_p && reset_n_i) begin
         assert (!(fe_if.fe_queue_v_i && full))
            else $error("fe_queue_v_i raised while queue full");
         assert (!(fe_if.fe_queue_yumi_i && !not_empty))
            else $error("fe_queue_yumi_i raised while fe_queue_v_o low");
         assert (!(fe_if.commit_v_i && (cptr_q == rptr_q)))
            else $error("commit_v_i raised with nothing dequeued");
      end
   end
endmodule

// File: tb/tb_bp_be_fe_queue_fifo.sv
// Directed bench for bp_be_fe_queue_fifo with els_p=4: fill, roll, commit, wrap, flush,
// roll+commit and asynchronous reset mid-operation.
module tb_bp_be_fe_queue_fifo;
   localparam int unsigned W = 16;
   localparam int unsigned N = 4;

   logic clk_i;
   logic reset_n_i;
   int   errors = 0;
   int   checks = 0;

   bp_be_fe_queue_fifo_if #(.fe_queue_width_p(W), .els_p(N)) q_if ();

   bp_be_fe_queue_fifo #(
      .fe_queue_width_p (W),
      .els_p            (N),
      .debug_p          (1'b0)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .fe_if     (q_if)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   // Apply one cycle of inputs, sample #1 after the edge, then idle the inputs.
   task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic cm,
                       input logic rl, input logic cl);
      q_if.fe_queue_v_i    = v;
      q_if.fe_queue_i      = d;
      q_if.fe_queue_yumi_i = y;
      q_if.commit_v_i      = cm;
      q_if.roll_v_i        = rl;
      q_if.clr_v_i         = cl;
      @(posedge clk_i);
      #1;
      q_if.fe_queue_v_i    = 1'b0;
      q_if.fe_queue_i      = '0;
      q_if.fe_queue_yumi_i = 1'b0;
      q_if.commit_v_i      = 1'b0;
      q_if.roll_v_i        = 1'b0;
      q_if.clr_v_i         = 1'b0;
   endtask

   task automatic status(input string tag, input logic v, input logic [W-1:0] d,
                         input logic rdy, input int cnt);
      chk({tag, ".v"}, 32'(q_if.fe_queue_v_o), 32'(v));
      if (v) chk({tag, ".data"}, 32'(q_if.fe_queue_o), 32'(d));
      chk({tag, ".ready"}, 32'(q_if.fe_queue_ready_o), 32'(rdy));
      chk({tag, ".count"}, 32'(q_if.count_o), 32'(cnt));
   endtask

   initial begin
      q_if.fe_queue_v_i    = 1'b0;
      q_if.fe_queue_i      = '0;
      q_if.fe_queue_yumi_i = 1'b0;
      q_if.commit_v_i      = 1'b0;
      q_if.roll_v_i        = 1'b0;
      q_if.clr_v_i         = 1'b0;
      reset_n_i            = 1'b0;
      #2;
      status("reset", 1'b0, '0, 1'b1, 0);
      chk("reset.data", 32'(q_if.fe_queue_o), 32'h0);
      #6 reset_n_i = 1'b1;

      // Fill A..D
      step(1, 16'hA0A0, 0, 0, 0, 0); status("enqA", 1, 16'hA0A0, 1, 1);
      step(1, 16'hB0B0, 0, 0, 0, 0);
      step(1, 16'hC0C0, 0, 0, 0, 0); status("enqC", 1, 16'hA0A0, 1, 3);
      step(1, 16'hD0D0, 0, 0, 0, 0); status("full", 1, 16'hA0A0, 0, 4);

      // Speculative dequeue, roll back, then commit one
      step(0, '0, 1, 0, 0, 0); status("yumiA", 1, 16'hB0B0, 0, 4);
      step(0, '0, 1, 0, 0, 0); status("yumiB", 1, 16'hC0C0, 0, 4);
      step(0, '0, 0, 0, 1, 0); status("roll", 1, 16'hA0A0, 0, 4);
      step(0, '0, 1, 0, 0, 0); status("reyumiA", 1, 16'hB0B0, 0, 4);
      step(0, '0, 0, 1, 0, 0); status("commit1", 1, 16'hB0B0, 1, 3);

      // Refill, then commit in the full cycle must not open ready combinationally
      step(1, 16'hE0E0, 0, 0, 0, 0); status("refull", 1, 16'hB0B0, 0, 4);
      step(0, '0, 1, 0, 0, 0); status("yumiB2", 1, 16'hC0C0, 0, 4);
      q_if.commit_v_i = 1'b1;
      #1;
      chk("fullcommit.ready_same", 32'(q_if.fe_queue_ready_o), 32'h0);
      @(posedge clk_i);
      #1;
      q_if.commit_v_i = 1'b0;
      status("fullcommit.next", 1, 16'hC0C0, 1, 3);
      step(0, '0, 1, 0, 0, 0); status("yumiC", 1, 16'hD0D0, 1, 3);
      step(0, '0, 1, 0, 0, 0); status("yumiD", 1, 16'hE0E0, 1, 3);
      step(0, '0, 1, 0, 0, 0); status("yumiE", 0, '0, 1, 3);
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0); status("drained", 0, '0, 1, 0);

      // Wrap-around rounds with simultaneous enqueue+yumi on a single available entry
      step(1, 16'h1000, 0, 0, 0, 0); status("wrap0", 1, 16'h1000, 1, 1);
      for (int i = 1; i <= 6; i++) begin
         step(1, W'(16'h1000 + i), 1, 0, 0, 0);
         status($sformatf("wrap%0d.enqyumi", i), 1, W'(16'h1000 + i), 1, 2);
         step(0, '0, 0, 1, 0, 0);
         chk($sformatf("wrap%0d.commit", i), 32'(q_if.count_o), 32'd1);
      end
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0); status("wrapdone", 0, '0, 1, 0);

      // Flush beats every same-cycle operation, including the enqueue
      step(1, 16'h5050, 0, 0, 0, 0);
      step(1, 16'h5151, 0, 0, 0, 0); status("preclr", 1, 16'h5050, 1, 2);
      step(1, 16'h5252, 1, 1, 1, 1); status("clr", 0, '0, 1, 0);
      step(1, 16'h5353, 0, 0, 0, 0); status("postclr", 1, 16'h5353, 1, 1);
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0); status("postclr.drain", 0, '0, 1, 0);

      // Roll with commit: checkpoint advances first, read pointer follows it
      step(1, 16'h6000, 0, 0, 0, 0);
      step(1, 16'h6001, 0, 0, 0, 0);
      step(1, 16'h6002, 0, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0); status("prerollc", 1, 16'h6002, 1, 3);
      step(0, '0, 0, 1, 1, 0); status("rollcommit", 1, 16'h6001, 1, 2);

      // Asynchronous reset between edges with three entries held
      step(1, 16'h6003, 0, 0, 0, 0); status("prereset", 1, 16'h6001, 1, 3);
      #3 reset_n_i = 1'b0;
      #1;
      status("asyncreset", 0, '0, 1, 0);
      chk("asyncreset.data", 32'(q_if.fe_queue_o), 32'h0);
      #2 reset_n_i = 1'b1;

      // Illegal yumi/commit on empty leave pointers alone
      step(0, '0, 1, 0, 0, 0); status("illyumi", 0, '0, 1, 0);
      chk("illyumi.data", 32'(q_if.fe_queue_o), 32'h0);
      step(0, '0, 0, 1, 0, 0); status("illcommit", 0, '0, 1, 0);
      step(1, 16'h7777, 0, 0, 0, 0); status("postreset.enq", 1, 16'h7777, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout: observed no finish expected finish by 20000");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
